// File: rtl/i2c_pwm_sequencer.sv
// Two-requester I2C single-byte writer: round-robin grant, 8-bit address, one data byte, STOP.
// Optional feature macro I2C_PWM_SEQ_RETRY_EN: retry the whole transfer once after an address NACK.
module i2c_pwm_sequencer #(
  parameter int QDIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic [7:0] ADDR0,
  input  logic [7:0] DATA0,
  input  logic       REQ1,
  input  logic [7:0] ADDR1,
  input  logic [7:0] DATA1,
  output logic [1:0] GNT,
  output logic       BUSY,
  output logic [1:0] DONE,
  output logic       ACK_ERR,
  output logic       SCL_OE,
  output logic       SDA_OE,
  input  logic       SDA_IN
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, FIN} state_t;

  state_t     state, nxt_state;
  logic [7:0] q, nxt_q;
  logic [1:0] tick, nxt_tick;
  logic [2:0] bit_idx, nxt_bit_idx;
  logic       err, nxt_err;
  logic       restart, nxt_restart;
`ifdef I2C_PWM_SEQ_RETRY_EN
  logic       retried, nxt_retried;
`endif
  logic [7:0] addr_q, data_q;
  logic       idx, last, nack;
  logic       wrap, sel1, nxt_bit_val;

  assign wrap        = (q == 8'(QDIV - 1));
  assign sel1        = REQ1 && (!REQ0 || !last);
  assign nxt_bit_val = (nxt_state == DATA) ? data_q[nxt_bit_idx] : addr_q[nxt_bit_idx];

  // Line drive for a given bit position, returned as {scl_oe, sda_oe}.
  function automatic logic [1:0] line_drive(state_t s, logic [1:0] t, logic b);
    case (s)
      START:        line_drive = {t == 2'd3, t >= 2'd2};
      ADDR, DATA:   line_drive = {(t == 2'd0) || (t == 2'd3), !b};
      ACK_A, ACK_D: line_drive = {(t == 2'd0) || (t == 2'd3), 1'b0};
      STOP:         line_drive = {t == 2'd0, t <= 2'd1};
      default:      line_drive = 2'b00;
    endcase
  endfunction

  always_comb begin
    nxt_state   = state;
    nxt_q       = q;
    nxt_tick    = tick;
    nxt_bit_idx = bit_idx;
    nxt_err     = err;
    nxt_restart = restart;
`ifdef I2C_PWM_SEQ_RETRY_EN
    nxt_retried = retried;
`endif
    case (state)
      IDLE: begin
        nxt_q    = '0;
        nxt_tick = '0;
        if (REQ0 || REQ1) nxt_state = START;
      end
      FIN: begin
        nxt_state   = IDLE;
        nxt_q       = '0;
        nxt_tick    = '0;
        nxt_err     = 1'b0;
        nxt_restart = 1'b0;
`ifdef I2C_PWM_SEQ_RETRY_EN
        nxt_retried = 1'b0;
`endif
      end
      default: begin
        if (!wrap) begin
          nxt_q = q + 8'd1;
        end else begin
          nxt_q    = '0;
          nxt_tick = tick + 2'd1;
          if (tick == 2'd3) begin
            case (state)
              START: begin
                nxt_state   = ADDR;
                nxt_bit_idx = 3'd7;
              end
              ADDR: begin
                if (bit_idx == 3'd0) nxt_state = ACK_A;
                else nxt_bit_idx = bit_idx - 3'd1;
              end
              DATA: begin
                if (bit_idx == 3'd0) nxt_state = ACK_D;
                else nxt_bit_idx = bit_idx - 3'd1;
              end
              ACK_A: begin
                if (nack) begin
                  nxt_state = STOP;
`ifdef I2C_PWM_SEQ_RETRY_EN
                  // First address NACK re-runs START after STOP; only the second reports an error.
                  if (!retried) begin
                    nxt_retried = 1'b1;
                    nxt_restart = 1'b1;
                  end else begin
                    nxt_err = 1'b1;
                  end
`else
                  nxt_err = 1'b1;
`endif
                end else begin
                  nxt_state   = DATA;
                  nxt_bit_idx = 3'd7;
                end
              end
              ACK_D: begin
                nxt_state = STOP;
                if (nack) nxt_err = 1'b1;
              end
              STOP: begin
                if (restart) begin
                  nxt_state   = START;
                  nxt_restart = 1'b0;
                end else begin
                  nxt_state = FIN;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Line outputs are registered from the position being entered, so they change only on tick boundaries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      q       <= '0;
      tick    <= '0;
      bit_idx <= '0;
      err     <= 1'b0;
      restart <= 1'b0;
`ifdef I2C_PWM_SEQ_RETRY_EN
      retried <= 1'b0;
`endif
      addr_q  <= '0;
      data_q  <= '0;
      idx     <= 1'b0;
      last    <= 1'b1;
      nack    <= 1'b0;
      GNT     <= '0;
      DONE    <= '0;
      BUSY    <= 1'b0;
      ACK_ERR <= 1'b0;
      SCL_OE  <= 1'b0;
      SDA_OE  <= 1'b0;
    end else begin
      state   <= nxt_state;
      q       <= nxt_q;
      tick    <= nxt_tick;
      bit_idx <= nxt_bit_idx;
      err     <= nxt_err;
      restart <= nxt_restart;
`ifdef I2C_PWM_SEQ_RETRY_EN
      retried <= nxt_retried;
`endif
      {SCL_OE, SDA_OE} <= line_drive(nxt_state, nxt_tick, nxt_bit_val);
      GNT     <= '0;
      DONE    <= '0;
      ACK_ERR <= 1'b0;
      if (state == IDLE && (REQ0 || REQ1)) begin
        GNT    <= sel1 ? 2'b10 : 2'b01;
        idx    <= sel1;
        last   <= sel1;
        addr_q <= sel1 ? ADDR1 : ADDR0;
        data_q <= sel1 ? DATA1 : DATA0;
        BUSY   <= 1'b1;
      end
      if (state == FIN) BUSY <= 1'b0;
      if (nxt_state == FIN) begin
        DONE    <= idx ? 2'b10 : 2'b01;
        ACK_ERR <= nxt_err;
      end
      if ((state == ACK_A || state == ACK_D) && tick == 2'd2 && wrap) nack <= SDA_IN;
    end
  end

endmodule
